key_event_scheduler: RTL and testbench

//  Debounces N_KEYS raw panel buttons with one shared 1 ms prescaler and one scan FSM,

---
 rtl/key_event_scheduler.sv | 152 +++++++++++++++
 tb/tb_key_event_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/key_event_scheduler.sv
// Debounces N_KEYS push-buttons using one shared sample prescaler and a channel scan FSM,
// queues one press event per key and issues them round-robin on a valid/ready port.
module key_event_scheduler #(
    parameter int N_KEYS       = 4,
    parameter int TICK_CYCLES  = 100000,
    parameter int STABLE_TICKS = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_KEYS-1:0]         keys_raw,
    output logic [N_KEYS-1:0]         keys_clean,
    output logic                      evt_valid,
    output logic [$clog2(N_KEYS)-1:0] evt_id,
    input  logic                      evt_ready,
    output logic                      evt_overrun
);

    localparam int unsigned NK  = N_KEYS;
    localparam int          IDW = $clog2(N_KEYS);
    localparam int          PW  = $clog2(TICK_CYCLES);
    localparam int          CW  = $clog2(STABLE_TICKS);

    localparam logic [PW-1:0]  TICK_LAST = PW'(TICK_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(STABLE_TICKS - 1);
    localparam logic [IDW-1:0] CH_LAST   = IDW'(N_KEYS - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SCAN = 1'b1;

    logic [N_KEYS-1:0] sync_meta;
    logic [N_KEYS-1:0] sync_q;
    logic [N_KEYS-1:0] cand;
    logic [CW-1:0]     cnt [N_KEYS];
    logic [PW-1:0]     presc;
    logic              tick;
    logic [0:0]        state;
    logic [IDW-1:0]    chan;
    logic [N_KEYS-1:0] pending;
    logic [IDW-1:0]    rr_ptr;

    logic [N_KEYS-1:0] visit;
    logic [N_KEYS-1:0] pend_set;
    logic [N_KEYS-1:0] pend_clr;
    logic [N_KEYS-1:0] pending_next;
    logic              sel_found;
    logic [IDW-1:0]    sel_idx;
    logic              issue;
    logic              overrun_next;
    logic [IDW-1:0]    rr_next;

    assign tick = (presc == TICK_LAST);

    // A press is recognised on the visit where a stable high candidate is committed.
    always_comb begin
        visit    = '0;
        pend_set = '0;
        for (int unsigned i = 0; i < NK; i++) begin
            visit[i] = (state == SCAN) && (chan == IDW'(i));
            if (visit[i] && (sync_q[i] == cand[i]) && (cnt[i] == CNT_LAST) &&
                !keys_clean[i] && cand[i])
                pend_set[i] = 1'b1;
        end
    end

    // Round-robin pick: first pending bit at or after rr_ptr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int unsigned off = 0; off < NK; off++) begin
            int unsigned j;
            j = (32'(rr_ptr) + off) % NK;
            if (!sel_found && pending[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDW'(j);
            end
        end
        issue    = (!evt_valid || evt_ready) && sel_found;
        pend_clr = '0;
        if (issue)
            pend_clr[sel_idx] = 1'b1;
        rr_next      = (sel_idx == CH_LAST) ? '0 : sel_idx + 1'b1;
        // Set wins over a same-cycle clear, and that case is not an overrun.
        overrun_next = |(pend_set & pending & ~pend_clr);
        pending_next = (pending & ~pend_clr) | pend_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_meta   <= '0;
            sync_q      <= '0;
            cand        <= '0;
            keys_clean  <= '0;
            presc       <= '0;
            state       <= IDLE;
            chan        <= '0;
            pending     <= '0;
            rr_ptr      <= '0;
            evt_valid   <= 1'b0;
            evt_id      <= '0;
            evt_overrun <= 1'b0;
            for (int unsigned i = 0; i < NK; i++)
                cnt[i] <= '0;
        end else begin
            sync_meta <= keys_raw;
            sync_q    <= sync_meta;
            presc     <= tick ? '0 : presc + 1'b1;

            case (state)
                IDLE: begin
                    if (tick) begin
                        state <= SCAN;
                        chan  <= '0;
                    end
                end
                SCAN: begin
                    if (chan == CH_LAST) begin
                        state <= IDLE;
                        chan  <= '0;
                    end else begin
                        chan <= chan + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            for (int unsigned i = 0; i < NK; i++) begin
                if (visit[i]) begin
                    if (sync_q[i] != cand[i]) begin
                        cand[i] <= sync_q[i];
                        cnt[i]  <= '0;
                    end else if (cnt[i] < CNT_LAST) begin
                        cnt[i] <= cnt[i] + 1'b1;
                    end else if (keys_clean[i] != cand[i]) begin
                        keys_clean[i] <= cand[i];
                    end
                end
            end

            pending     <= pending_next;
            evt_overrun <= overrun_next;

            if (issue) begin
                evt_valid <= 1'b1;
                evt_id    <= sel_idx;
                rr_ptr    <= rr_next;
            end else if (evt_valid && evt_ready) begin
                evt_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_key_event_scheduler.sv
// Scoreboard bench for key_event_scheduler: expected event ids are queued when presses are
// driven and popped on each accepted handshake.
module tb_key_event_scheduler;

    localparam int N  = 4;
    localparam int TC = 8;
    localparam int ST = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] keys_raw;
    logic [N-1:0] keys_clean;
    logic         evt_valid;
    logic [1:0]   evt_id;
    logic         evt_ready;
    logic         evt_overrun;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int ovr_cnt     = 0;
    int ovr_base    = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    key_event_scheduler #(
        .N_KEYS      (N),
        .TICK_CYCLES (TC),
        .STABLE_TICKS(ST)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .keys_raw   (keys_raw),
        .keys_clean (keys_clean),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .evt_overrun(evt_overrun)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Edges since reset release; each scan ends on the edge where cyc % TC == N.
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    // Inputs change only just after posedge, so valid&ready seen here is the next handshake.
    always @(negedge clk) begin
        if (!reset) begin
            if (evt_overrun) ovr_cnt++;
            if (evt_valid && evt_ready) begin
                check_val("evt_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0)
                    check_val("evt_id", 32'(evt_id), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic wait_scans(input int n);
        repeat (n) begin
            @(negedge clk);
            while (cyc % TC != N) @(negedge clk);
        end
    endtask

    task automatic drive_ready(input logic v);
        @(posedge clk);
        #1 evt_ready = v;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors %0d", vectors);
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        keys_raw  = '0;
        evt_ready = 1'b0;
        repeat (3) @(negedge clk);
        check_val("rst_clean",   32'(keys_clean),  32'd0);
        check_val("rst_valid",   32'(evt_valid),   32'd0);
        check_val("rst_id",      32'(evt_id),      32'd0);
        check_val("rst_overrun", 32'(evt_overrun), 32'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        // 1: single press of key 2
        wait_scans(1);
        keys_raw[2] = 1'b1;
        exp_q.push_back(2);
        wait_scans(3);
        check_val("t1_clean_early", 32'(keys_clean[2]), 32'd0);
        check_val("t1_valid_early", 32'(evt_valid),     32'd0);
        wait_scans(1);
        check_val("t1_clean", 32'(keys_clean[2]), 32'd1);
        check_val("t1_valid", 32'(evt_valid),     32'd1);
        check_val("t1_id",    32'(evt_id),        32'd2);
        drive_ready(1'b1);
        repeat (2) @(negedge clk);
        check_val("t1_valid_drop", 32'(evt_valid), 32'd0);

        // 2: bounce on key 0, each level held only 2 ticks
        wait_scans(1);
        for (int k = 0; k < 6; k++) begin
            keys_raw[0] = ~keys_raw[0];
            wait_scans(2);
            check_val("t2_clean", 32'(keys_clean[0]), 32'd0);
        end
        wait_scans(4);
        check_val("t2_clean_end", 32'(keys_clean[0]), 32'd0);
        check_val("t2_valid",     32'(evt_valid),     32'd0);

        // 3: keys 1 and 3 together with back-pressure
        drive_ready(1'b0);
        wait_scans(1);
        keys_raw[1] = 1'b1;
        keys_raw[3] = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(3);
        wait_scans(4);
        check_val("t3_valid", 32'(evt_valid), 32'd1);
        check_val("t3_id",    32'(evt_id),    32'd1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k % 10 == 9) begin
                check_val("t3_hold_valid", 32'(evt_valid), 32'd1);
                check_val("t3_hold_id",    32'(evt_id),    32'd1);
            end
        end
        drive_ready(1'b1);
        repeat (4) @(negedge clk);
        check_val("t3_valid_end", 32'(evt_valid),    32'd0);
        check_val("t3_sb_empty",  32'(exp_q.size()), 32'd0);
        wait_scans(1);
        keys_raw[1] = 1'b0;
        wait_scans(4);
        check_val("t3_rel_clean1", 32'(keys_clean[1]), 32'd0);
        check_val("t3_held_clean3", 32'(keys_clean[3]), 32'd1);

        // 4: key 0 occupies the slot, key 1 pressed twice -> merge with overrun
        drive_ready(1'b0);
        ovr_base = ovr_cnt;
        wait_scans(1);
        keys_raw[0] = 1'b1;
        exp_q.push_back(0);
        wait_scans(4);
        check_val("t4_valid", 32'(evt_valid), 32'd1);
        check_val("t4_id0",   32'(evt_id),    32'd0);
        keys_raw[1] = 1'b1;
        exp_q.push_back(1);
        wait_scans(4);
        check_val("t4_no_ovr_yet", 32'(ovr_cnt - ovr_base), 32'd0);
        keys_raw[1] = 1'b0;
        wait_scans(4);
        check_val("t4_rel_clean1", 32'(keys_clean[1]), 32'd0);
        keys_raw[1] = 1'b1;
        wait_scans(4);
        check_val("t4_overrun",   32'(ovr_cnt - ovr_base), 32'd1);
        check_val("t4_clean1",    32'(keys_clean[1]),      32'd1);
        check_val("t4_id_stable", 32'(evt_id),             32'd0);
        drive_ready(1'b1);
        repeat (6) @(negedge clk);
        check_val("t4_valid_end", 32'(evt_valid),          32'd0);
        check_val("t4_sb_empty",  32'(exp_q.size()),       32'd0);
        check_val("t4_ovr_once",  32'(ovr_cnt - ovr_base), 32'd1);

        // 5: release of key 3 makes no event
        wait_scans(1);
        keys_raw[3] = 1'b0;
        wait_scans(3);
        check_val("t5_clean_early", 32'(keys_clean[3]), 32'd1);
        wait_scans(1);
        check_val("t5_clean", 32'(keys_clean[3]), 32'd0);
        check_val("t5_valid", 32'(evt_valid),     32'd0);
        keys_raw = '0;
        wait_scans(5);
        check_val("t5_all_released", 32'(keys_clean), 32'd0);

        // 6: reset during SCAN with an event held and another pending
        drive_ready(1'b0);
        wait_scans(1);
        keys_raw[1] = 1'b1;
        keys_raw[2] = 1'b1;
        wait_scans(4);
        check_val("t6_valid", 32'(evt_valid), 32'd1);
        check_val("t6_id",    32'(evt_id),    32'd1);
        @(negedge clk);
        while (cyc % TC != 1) @(negedge clk);
        reset    = 1'b1;
        keys_raw = '0;
        #1;
        check_val("t6_rst_clean",   32'(keys_clean),  32'd0);
        check_val("t6_rst_valid",   32'(evt_valid),   32'd0);
        check_val("t6_rst_id",      32'(evt_id),      32'd0);
        check_val("t6_rst_overrun", 32'(evt_overrun), 32'd0);
        drive_ready(1'b1);
        @(posedge clk);
        #1 reset = 1'b0;
        wait_scans(6);
        check_val("t6_post_valid", 32'(evt_valid),    32'd0);
        check_val("t6_post_clean", 32'(keys_clean),   32'd0);
        check_val("final_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
